// File: rtl/key_debouncer_if.sv
// Key debouncer signal bundle: raw button pins in, debounced level and strobes out.
interface key_debouncer_if #(
  parameter int NKEYS = 4
);
  logic [NKEYS-1:0] keys_raw;
  logic [NKEYS-1:0] keys_db;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_repeat;

  modport master (
    output keys_raw,
    input  keys_db, key_press, key_release, key_repeat
  );

  modport slave (
    input  keys_raw,
    output keys_db, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-FF synchronizer plus debounce FSM with press/release/auto-repeat strobes.
//   state       | meaning
//   RELEASED    | key stable released, keys_db=0
//   PRESS_CHK   | key seen pressed, counting stable cycles before accepting
//   PRESSED     | key stable pressed, keys_db=1, repeat timer running
//   RELEASE_CHK | key seen released, counting stable cycles before accepting
module key_debouncer #(
  parameter int NKEYS      = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DB_CYCLES  = 250000,
  parameter bit REP_EN     = 1'b1,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic           clk,
  input  logic           reset,
  key_debouncer_if.slave kif
);

  localparam int CW      = $clog2(DB_CYCLES);
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [CW-1:0] DB_LAST         = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;

  logic [NKEYS-1:0] pressed_raw;
  logic [NKEYS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NKEYS-1:0] db_q, db_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [NKEYS-1:0] release_q, release_d;
  logic [NKEYS-1:0] repeat_q, repeat_d;
  logic [NKEYS-1:0] rep_first_q, rep_first_d;

  db_state_e     state_q [NKEYS];
  db_state_e     state_d [NKEYS];
  logic [CW-1:0] cnt_q   [NKEYS];
  logic [CW-1:0] cnt_d   [NKEYS];
  logic [RW-1:0] rep_q   [NKEYS];
  logic [RW-1:0] rep_d   [NKEYS];

  assign pressed_raw = ACTIVE_LOW ? ~kif.keys_raw : kif.keys_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      db_q        <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      rep_first_q <= '1;
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
        rep_q[k]   <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_q        <= db_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      rep_first_q <= rep_first_d;
      for (int k = 0; k < NKEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        rep_q[k]   <= rep_d[k];
      end
    end
  end

  always_comb begin
    s1_d        = pressed_raw;
    s2_d        = s1_q;
    db_d        = db_q;
    press_d     = '0;
    release_d   = '0;
    repeat_d    = '0;
    rep_first_d = rep_first_q;
    for (int k = 0; k < NKEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      rep_d[k]   = rep_q[k];

      case (state_q[k])
        RELEASED: begin
          if (s2_q[k]) begin
            state_d[k] = PRESS_CHK;
            cnt_d[k]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s2_q[k]) begin
            state_d[k] = RELEASED;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k]     = PRESSED;
            db_d[k]        = 1'b1;
            press_d[k]     = 1'b1;
            rep_d[k]       = '0;
            rep_first_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_q[k]) begin
            state_d[k] = RELEASE_CHK;
            cnt_d[k]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (s2_q[k]) begin
            state_d[k] = PRESSED;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k]     = RELEASED;
            db_d[k]        = 1'b0;
            release_d[k]   = 1'b1;
            rep_d[k]       = '0;
            rep_first_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end
      endcase

      // Repeat timer runs while held; the release edge wins so strobes never overlap.
      if ((state_q[k] == PRESSED || state_q[k] == RELEASE_CHK) && !release_d[k]) begin
        if (rep_q[k] == (rep_first_q[k] ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
          rep_d[k]       = '0;
          rep_first_d[k] = 1'b0;
          repeat_d[k]    = REP_EN;
        end else begin
          rep_d[k] = rep_q[k] + 1'b1;
        end
      end
    end
  end

  assign kif.keys_db     = db_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with short debounce and repeat timings.
module tb_key_debouncer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  key_debouncer_if #(.NKEYS(4)) kif ();

  key_debouncer #(
    .NKEYS(4), .ACTIVE_LOW(1'b1), .DB_CYCLES(4),
    .REP_EN(1'b1), .REP_DELAY(10), .REP_PERIOD(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kif(kif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time just past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_db"},  32'(kif.keys_db),     32'h0);
    check_eq({tag, "_prs"}, 32'(kif.key_press),   32'h0);
    check_eq({tag, "_rel"}, 32'(kif.key_release), 32'h0);
    check_eq({tag, "_rep"}, 32'(kif.key_repeat),  32'h0);
  endtask

  logic acc;
  logic acc_db;
  logic exp_rep;

  initial begin
    reset = 1'b0;
    kif.keys_raw = 4'hF;
    step(2);
    check_all_zero("rst_hold");
    reset = 1'b1;
    step(3);
    check_all_zero("rst_idle");

    // T1 clean press on key 0
    kif.keys_raw[0] = 1'b0;
    step(6);
    check_eq("t1_db_early",  32'(kif.keys_db),   32'h0);
    check_eq("t1_prs_early", 32'(kif.key_press), 32'h0);
    step(1);
    check_eq("t1_db",  32'(kif.keys_db),   32'h1);
    check_eq("t1_prs", 32'(kif.key_press), 32'h1);
    step(1);
    check_eq("t1_prs_width", 32'(kif.key_press), 32'h0);
    check_eq("t1_db_hold",   32'(kif.keys_db),   32'h1);

    // T3 one-cycle release glitch, then clean release
    kif.keys_raw[0] = 1'b1;
    step(1);
    kif.keys_raw[0] = 1'b0;
    acc = 1'b0;
    acc_db = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc    = acc | kif.key_release[0];
      acc_db = acc_db & kif.keys_db[0];
    end
    check_eq("t3_glitch_rel", 32'(acc),    32'h0);
    check_eq("t3_glitch_db",  32'(acc_db), 32'h1);
    kif.keys_raw[0] = 1'b1;
    step(6);
    check_eq("t3_db_early", 32'(kif.keys_db[0]), 32'h1);
    step(1);
    check_eq("t3_db",  32'(kif.keys_db),     32'h0);
    check_eq("t3_rel", 32'(kif.key_release), 32'h1);
    step(1);
    check_eq("t3_rel_width", 32'(kif.key_release), 32'h0);

    // T2 bounce on key 1: 2-cycle segments never reach the debounce count
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      kif.keys_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      acc = acc | kif.key_press[1] | kif.key_release[1] | kif.keys_db[1];
      step(1);
      acc = acc | kif.key_press[1] | kif.key_release[1] | kif.keys_db[1];
    end
    kif.keys_raw[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      acc = acc | kif.key_press[1] | kif.keys_db[1];
    end
    check_eq("t2_bounce_quiet", 32'(acc), 32'h0);
    step(1);
    check_eq("t2_prs", 32'(kif.key_press), 32'h2);
    check_eq("t2_db",  32'(kif.keys_db),   32'h2);
    kif.keys_raw[1] = 1'b1;
    step(8);
    check_eq("t2_released", 32'(kif.keys_db), 32'h0);

    // T4 auto-repeat on key 2
    kif.keys_raw[2] = 1'b0;
    step(7);
    check_eq("t4_prs",     32'(kif.key_press[2]),  32'h1);
    check_eq("t4_rep_at0", 32'(kif.key_repeat[2]), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      step(1);
      exp_rep = (k == 10 || k == 15 || k == 20 || k == 25 || k == 30);
      check_eq($sformatf("t4_rep_p%0d", k), 32'(kif.key_repeat[2]), 32'(exp_rep));
    end
    kif.keys_raw[2] = 1'b1;
    step(7);
    check_eq("t4_rel", 32'(kif.key_release[2]), 32'h1);
    check_eq("t4_db",  32'(kif.keys_db[2]),     32'h0);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      acc = acc | kif.key_repeat[2];
    end
    check_eq("t4_no_rep_after", 32'(acc), 32'h0);

    // T5 multi-key press, partial release, simultaneous press and release
    kif.keys_raw[0] = 1'b0;
    kif.keys_raw[3] = 1'b0;
    step(6);
    check_eq("t5_prs_early", 32'(kif.key_press), 32'h0);
    step(1);
    check_eq("t5_prs", 32'(kif.key_press), 32'h9);
    check_eq("t5_db",  32'(kif.keys_db),   32'h9);
    kif.keys_raw[0] = 1'b1;
    step(7);
    check_eq("t5_rel0",     32'(kif.key_release), 32'h1);
    check_eq("t5_db_1000",  32'(kif.keys_db),     32'h8);
    kif.keys_raw[1] = 1'b0;
    kif.keys_raw[3] = 1'b1;
    step(7);
    check_eq("t5_sim_prs", 32'(kif.key_press),   32'h2);
    check_eq("t5_sim_rel", 32'(kif.key_release), 32'h8);
    check_eq("t5_sim_db",  32'(kif.keys_db),     32'h2);
    kif.keys_raw[1] = 1'b1;
    step(8);
    check_eq("t5_idle", 32'(kif.keys_db), 32'h0);

    // T6 reset while PRESSED, key kept held
    kif.keys_raw[0] = 1'b0;
    step(7);
    check_eq("t6_prs", 32'(kif.keys_db), 32'h1);
    step(3);
    reset = 1'b0;
    #1;
    check_all_zero("t6_rst_pressed");
    step(2);
    reset = 1'b1;
    step(6);
    check_eq("t6_db_early", 32'(kif.keys_db), 32'h0);
    step(1);
    check_eq("t6_reacc_db",  32'(kif.keys_db),   32'h1);
    check_eq("t6_reacc_prs", 32'(kif.key_press), 32'h1);

    // T6 reset while PRESS_CHK
    kif.keys_raw[0] = 1'b1;
    step(8);
    check_eq("t6_released", 32'(kif.keys_db), 32'h0);
    kif.keys_raw[0] = 1'b0;
    step(4);
    reset = 1'b0;
    #1;
    check_all_zero("t6_rst_chk");
    step(1);
    reset = 1'b1;
    step(6);
    check_eq("t6_chk_db_early", 32'(kif.keys_db), 32'h0);
    step(1);
    check_eq("t6_chk_reacc_prs", 32'(kif.key_press), 32'h1);
    check_eq("t6_chk_reacc_db",  32'(kif.keys_db),   32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
